// File: rtl/processor_edge_in.sv
// Avalon-MM input PIO: synchronizer, optional debounce, edge detect,
// sticky capture with per-bit mask and a level interrupt.
module processor_edge_in #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] capture;
  logic             wr;
  logic             unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // In bypass the last synchronizer flop is the filtered register,
  // so filt lands SYNC_STAGES edges after the input change.
  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign filt = sync;
  end else begin : g_debounce
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] filt_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        filt_q <= '0;
        for (int b = 0; b < WIDTH; b++) begin
          cnt[b] <= '0;
        end
      end else begin
        for (int b = 0; b < WIDTH; b++) begin
          if (sync[b] == filt_q[b]) begin
            cnt[b] <= '0;
          end else if (cnt[b] == CNT_LAST) begin
            filt_q[b] <= sync[b];
            cnt[b]    <= '0;
          end else begin
            cnt[b] <= cnt[b] + 1'b1;
          end
        end
      end
    end

    assign filt = filt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= filt;
    end
  end

  assign rise = filt & ~prev;
  assign fall = ~filt & prev;

  always_comb begin
    ev = rise | fall;
    if (EDGE_TYPE == 0) begin
      ev = rise;
    end else if (EDGE_TYPE == 1) begin
      ev = fall;
    end
  end

  assign wr  = chipselect & ~write_n;
  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A new event wins over a same-cycle software clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask    <= '0;
      capture <= '0;
    end else begin
      capture <= (capture & ~clr) | ev;
      if (wr && address == 2'd2) begin
        mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata[WIDTH-1:0] = filt;
      2'd1: readdata = '0;
      2'd2: readdata[WIDTH-1:0] = mask;
      2'd3: readdata[WIDTH-1:0] = capture;
    endcase
  end

  assign irq = |(capture & mask);

  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_processor_edge_in.sv
// Bench for processor_edge_in: four parameter sets share one bus and
// input port; directed scenarios plus a random run against a model.
module tb_processor_edge_in;

  localparam int SYNC = 2;
  localparam int MDB [4] = '{0, 4, 0, 0};
  localparam int MET [4] = '{0, 0, 1, 2};

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [1:0]       in_port;
  logic [3:0][31:0] rd;
  logic [3:0]       irqv;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] inq [16];
  logic [1:0] mf [4];
  logic [1:0] mp [4];
  logic [1:0] mcap [4];
  logic [1:0] mmask [4];

  always #5 clk = ~clk;

  processor_edge_in #(.WIDTH(2), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port),
    .readdata(rd[0]), .irq(irqv[0]));

  processor_edge_in #(.WIDTH(2), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port),
    .readdata(rd[1]), .irq(irqv[1]));

  processor_edge_in #(.WIDTH(2), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port),
    .readdata(rd[2]), .irq(irqv[2]));

  processor_edge_in #(.WIDTH(2), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u3 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port),
    .readdata(rd[3]), .irq(irqv[3]));

  // Model: input history per edge; filt is the input seen SYNC edges
  // ago, or flips once the last N synchronized samples all disagree.
  task automatic model_edge();
    logic [1:0] clr;
    logic [1:0] ev;
    logic [1:0] nf;
    logic       wen;
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) inq[i] = 2'b00;
      for (int d = 0; d < 4; d++) begin
        mf[d] = 2'b00;
        mp[d] = 2'b00;
        mcap[d] = 2'b00;
        mmask[d] = 2'b00;
      end
    end else begin
      wen = chipselect && !write_n;
      clr = (wen && address == 2'd3) ? writedata[1:0] : 2'b00;
      for (int i = 15; i > 0; i--) inq[i] = inq[i-1];
      inq[0] = in_port;
      for (int d = 0; d < 4; d++) begin
        case (MET[d])
          0: ev = mf[d] & ~mp[d];
          1: ev = ~mf[d] & mp[d];
          default: ev = mf[d] ^ mp[d];
        endcase
        if (MDB[d] == 0) begin
          nf = inq[SYNC-1];
        end else begin
          nf = mf[d];
          for (int b = 0; b < 2; b++) begin
            int run;
            run = 0;
            for (int j = 0; j < MDB[d]; j++)
              if (inq[SYNC+j][b] != mf[d][b]) run++;
            if (run == MDB[d]) nf[b] = ~mf[d][b];
          end
        end
        mp[d] = mf[d];
        mf[d] = nf;
        mcap[d] = (mcap[d] & ~clr) | ev;
        if (wen && address == 2'd2) mmask[d] = writedata[1:0];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = d;
    step();
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_port = 2'b11;
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
    address = 2'd0;
    repeat (3) step();
    vectors++;
    if (irqv !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_irq: got %b want 0000", irqv);
    end
    for (int a = 0; a < 4; a++) begin
      address = a[1:0];
      #1;
      for (int d = 0; d < 4; d++) begin
        vectors++;
        if (rd[d] !== 32'd0) begin
          miscompares++;
          $display("FAIL reset_rd dut%0d addr%0d: got %h want 0",
                   d, a, rd[d]);
        end
      end
    end
    reset_n = 1'b1;
    address = 2'd0;
    step();
    vectors++;
    if (rd[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_filt_e1: got %h want 0", rd[0]);
    end
    step();
    vectors++;
    if (rd[0] !== 32'd3) begin
      miscompares++;
      $display("FAIL reset_filt_e2: got %h want 3", rd[0]);
    end
    step();
    address = 2'd3;
    #1;
    vectors++;
    if (rd[0] !== 32'd3) begin
      miscompares++;
      $display("FAIL reset_capture: got %h want 3", rd[0]);
    end
  endtask

  task automatic test_rise_irq();
    in_port = 2'b00;
    repeat (8) step();
    bus_write(2'd2, 32'd1);
    bus_write(2'd3, 32'd3);
    vectors++;
    if (irqv[0] !== 1'b0 || rd[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL rise_cleared: irq %b cap %h want 0 0", irqv[0], rd[0]);
    end
    in_port = 2'b01;
    step();
    step();
    vectors++;
    if (irqv[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rise_irq_early: got %b want 0", irqv[0]);
    end
    step();
    vectors++;
    if (irqv[0] !== 1'b1 || rd[0] !== 32'd1) begin
      miscompares++;
      $display("FAIL rise_irq: irq %b cap %h want 1 1", irqv[0], rd[0]);
    end
    in_port = 2'b11;
    repeat (3) step();
    vectors++;
    if (irqv[0] !== 1'b1 || rd[0] !== 32'd3) begin
      miscompares++;
      $display("FAIL rise_bit1: irq %b cap %h want 1 3", irqv[0], rd[0]);
    end
    bus_write(2'd3, 32'd1);
    address = 2'd3;
    #1;
    vectors++;
    if (irqv[0] !== 1'b0 || rd[0] !== 32'd2) begin
      miscompares++;
      $display("FAIL rise_clear0: irq %b cap %h want 0 2", irqv[0], rd[0]);
    end
  endtask

  task automatic test_collision();
    bus_write(2'd3, 32'd3);
    in_port = 2'b00;
    repeat (6) step();
    in_port = 2'b01;
    step();
    step();
    address = 2'd3;
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = 32'd1;
    step();
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
    #1;
    vectors++;
    if (rd[0] !== 32'd1 || irqv[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL collision: cap %h irq %b want 1 1", rd[0], irqv[0]);
    end
    step();
    vectors++;
    if (irqv[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_hold: irq %b want 1", irqv[0]);
    end
  endtask

  task automatic test_debounce();
    in_port = 2'b00;
    repeat (10) step();
    bus_write(2'd3, 32'd3);
    in_port = 2'b01;
    repeat (3) step();
    in_port = 2'b00;
    repeat (8) step();
    address = 2'd0;
    #1;
    vectors++;
    if (rd[1] !== 32'd0) begin
      miscompares++;
      $display("FAIL db_short_filt: got %h want 0", rd[1]);
    end
    address = 2'd3;
    #1;
    vectors++;
    if (rd[1] !== 32'd0) begin
      miscompares++;
      $display("FAIL db_short_cap: got %h want 0", rd[1]);
    end
    in_port = 2'b01;
    repeat (4) step();
    in_port = 2'b00;
    address = 2'd0;
    step();
    vectors++;
    if (rd[1] !== 32'd0) begin
      miscompares++;
      $display("FAIL db_filt_e5: got %h want 0", rd[1]);
    end
    step();
    vectors++;
    if (rd[1] !== 32'd1) begin
      miscompares++;
      $display("FAIL db_filt_e6: got %h want 1", rd[1]);
    end
    step();
    address = 2'd3;
    #1;
    vectors++;
    if (rd[1] !== 32'd1) begin
      miscompares++;
      $display("FAIL db_cap: got %h want 1", rd[1]);
    end
  endtask

  task automatic test_edge_modes();
    in_port = 2'b00;
    repeat (10) step();
    bus_write(2'd3, 32'd3);
    in_port = 2'b01;
    repeat (4) step();
    address = 2'd3;
    #1;
    vectors++;
    if (rd[2] !== 32'd0 || rd[3] !== 32'd1) begin
      miscompares++;
      $display("FAIL edge_rise: fall %h any %h want 0 1", rd[2], rd[3]);
    end
    bus_write(2'd3, 32'd3);
    address = 2'd3;
    #1;
    vectors++;
    if (rd[3] !== 32'd0) begin
      miscompares++;
      $display("FAIL edge_clear: any %h want 0", rd[3]);
    end
    in_port = 2'b00;
    repeat (4) step();
    vectors++;
    if (rd[2] !== 32'd1 || rd[3] !== 32'd1) begin
      miscompares++;
      $display("FAIL edge_fall: fall %h any %h want 1 1", rd[2], rd[3]);
    end
  endtask

  task automatic test_reset_midcount();
    in_port = 2'b00;
    repeat (10) step();
    in_port = 2'b01;
    repeat (4) step();
    reset_n = 1'b0;
    address = 2'd0;
    #1;
    vectors++;
    if (rd[1] !== 32'd0 || irqv !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_clear: filt %h irq %b want 0 0", rd[1], irqv);
    end
    repeat (2) step();
    reset_n = 1'b1;
    repeat (5) step();
    vectors++;
    if (rd[1] !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_e5: got %h want 0", rd[1]);
    end
    step();
    vectors++;
    if (rd[1] !== 32'd1) begin
      miscompares++;
      $display("FAIL midreset_e6: got %h want 1", rd[1]);
    end
  endtask

  task automatic test_random();
    logic [1:0]  a;
    logic [31:0] exp;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) in_port = 2'($urandom);
      chipselect = 1'($urandom_range(0, 1));
      write_n = ($urandom_range(0, 3) != 0);
      address = 2'($urandom);
      writedata = $urandom;
      step();
      chipselect = 1'b0;
      write_n = 1'b1;
      a = 2'($urandom);
      address = a;
      #1;
      for (int d = 0; d < 4; d++) begin
        vectors++;
        if (irqv[d] !== |(mcap[d] & mmask[d])) begin
          miscompares++;
          $display("FAIL rand_irq dut%0d cyc%0d: got %b want %b",
                   d, n, irqv[d], |(mcap[d] & mmask[d]));
        end
        case (a)
          2'd0: exp = {30'd0, mf[d]};
          2'd2: exp = {30'd0, mmask[d]};
          2'd3: exp = {30'd0, mcap[d]};
          default: exp = 32'd0;
        endcase
        vectors++;
        if (rd[d] !== exp) begin
          miscompares++;
          $display("FAIL rand_rd dut%0d cyc%0d addr%0d: got %h want %h",
                   d, n, a, rd[d], exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise_irq();
    test_collision();
    test_debounce();
    test_edge_modes();
    test_reset_midcount();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
